// File: rtl/generic_sram_1rw1r_banked_pkg.sv
// rtl/generic_sram_1rw1r_banked_pkg.sv - shared types and helpers for the banked 1RW+1R SRAM
//
// Purpose: technology selectors, init FSM state type and the byte-merge helper
//          used by the inferred bank model.
// Contents:
//   TECHNO_INFERRED / TECHNO_SKYWATER  values for the TECHNO parameter
//   state_t                            {ST_INIT, ST_RUN}
//   mask_merge(old_data, new_data, mask) one byte lane: new when mask set, else old

package generic_sram_pkg;

  localparam int TECHNO_INFERRED = 0;
  localparam int TECHNO_SKYWATER = 1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  function automatic logic [7:0] mask_merge(input logic [7:0] old_data,
                                            input logic [7:0] new_data,
                                            input logic       mask);
    return mask ? new_data : old_data;
  endfunction

endpackage

// File: rtl/sky130_sram_1kbyte_1rw1r_8x1024_8.sv
// rtl/sky130_sram_1kbyte_1rw1r_8x1024_8.sv - behavioural stand-in for the SkyWater 1kbyte 1rw1r macro
//
// Purpose: port-compatible model of the 8x1024 1rw1r macro so the TECHNO=1 path
//          elaborates without the foundry library. Active-low selects, registered reads.
// Ports:
//   clk0, csb0, web0, wmask0, addr0, din0, dout0   read/write port
//   clk1, csb1, addr1, dout1                       read-only port

module sky130_sram_1kbyte_1rw1r_8x1024_8 (
  input  logic       clk0,
  input  logic       csb0,
  input  logic       web0,
  input  logic [0:0] wmask0,
  input  logic [9:0] addr0,
  input  logic [7:0] din0,
  output logic [7:0] dout0,
  input  logic       clk1,
  input  logic       csb1,
  input  logic [9:0] addr1,
  output logic [7:0] dout1
);

  logic [7:0] mem [1024];

  always_ff @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) begin
        if (wmask0[0]) mem[addr0] <= din0;
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (!csb1) dout1 <= mem[addr1];
  end

endmodule

// File: rtl/sram_bank_1rw1r.sv
// rtl/sram_bank_1rw1r.sv - one SRAM bank, 1RW + 1R, per-byte write mask
//
// Purpose: single bank of 2**BANK_ASIZE words. Read data is registered and held
//          until the next read on the same port; writes do not disturb rdata0.
// Ports:
//   clk                 clock for both ports
//   cs0, we0, wmask0    port-0 select, write enable, byte enables
//   addr0, wdata0       port-0 row and write data
//   rdata0              port-0 registered read data
//   cs1, addr1          port-1 select and row
//   rdata1              port-1 registered read data

module sram_bank_1rw1r
  import generic_sram_pkg::*;
#(
  parameter int TECHNO     = TECHNO_SKYWATER,
  parameter int BANK_ASIZE = 10,
  parameter int DSIZE      = 32,
  parameter int MSIZE      = DSIZE / 8
) (
  input  logic                  clk,
  input  logic                  cs0,
  input  logic                  we0,
  input  logic [MSIZE-1:0]      wmask0,
  input  logic [BANK_ASIZE-1:0] addr0,
  input  logic [DSIZE-1:0]      wdata0,
  output logic [DSIZE-1:0]      rdata0,
  input  logic                  cs1,
  input  logic [BANK_ASIZE-1:0] addr1,
  output logic [DSIZE-1:0]      rdata1
);

  if (TECHNO == TECHNO_INFERRED) begin : g_inferred

    logic [DSIZE-1:0] mem [2**BANK_ASIZE];

    always_ff @(posedge clk) begin
      if (cs0) begin
        if (we0) begin
          for (int i = 0; i < MSIZE; i++) begin
            mem[addr0][8*i +: 8] <= mask_merge(mem[addr0][8*i +: 8], wdata0[8*i +: 8], wmask0[i]);
          end
        end else begin
          rdata0 <= mem[addr0];
        end
      end
      if (cs1) rdata1 <= mem[addr1];
    end

  end else begin : g_sky130

    // One 8-bit macro per byte lane; a lane with its mask bit clear is simply
    // not selected during a write, so it neither writes nor disturbs dout0.
    for (genvar i = 0; i < MSIZE; i++) begin : g_lane
      sky130_sram_1kbyte_1rw1r_8x1024_8 u_macro (
        .clk0   (clk),
        .csb0   (!(cs0 && (!we0 || wmask0[i]))),
        .web0   (!we0),
        .wmask0 (1'b1),
        .addr0  (addr0),
        .din0   (wdata0[8*i +: 8]),
        .dout0  (rdata0[8*i +: 8]),
        .clk1   (clk),
        .csb1   (!cs1),
        .addr1  (addr1),
        .dout1  (rdata1[8*i +: 8])
      );
    end

  end

endmodule

// File: rtl/generic_sram_1rw1r_banked.sv
// rtl/generic_sram_1rw1r_banked.sv - banked 1RW+1R SRAM with valid/ready ports
//
// Purpose: spreads 2**ASIZE words over NBANKS banks; bank decode, write/read
//          collision stall on port 1, one-cycle registered read responses.
//          Optional zero-fill after reset when GENERIC_SRAM_INIT_EN is defined.
// Ports:
//   clk, rst                                        clock, sync active-high reset
//   req0_valid/ready/we/wmask/addr/wdata            port-0 read/write request
//   rsp0_valid, rsp0_rdata                          port-0 read response
//   req1_valid/ready/addr                           port-1 read request
//   rsp1_valid, rsp1_rdata                          port-1 read response

module generic_sram_1rw1r_banked
  import generic_sram_pkg::*;
#(
  parameter int TECHNO     = TECHNO_SKYWATER,
  parameter int ASIZE      = 12,
  parameter int BANK_ASIZE = 10,
  parameter int DSIZE      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_we,
  input  logic [DSIZE/8-1:0] req0_wmask,
  input  logic [ASIZE-1:0]   req0_addr,
  input  logic [DSIZE-1:0]   req0_wdata,
  output logic               rsp0_valid,
  output logic [DSIZE-1:0]   rsp0_rdata,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [ASIZE-1:0]   req1_addr,
  output logic               rsp1_valid,
  output logic [DSIZE-1:0]   rsp1_rdata
);

  localparam int MSIZE  = DSIZE / 8;
  localparam int BSEL   = ASIZE - BANK_ASIZE;
  localparam int NBANKS = 2 ** BSEL;

  logic                  run;
  logic                  init_active;
  logic [BANK_ASIZE-1:0] init_row;

`ifdef GENERIC_SRAM_INIT_EN
  state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_row <= '0;
    end else if (state == ST_INIT) begin
      init_row <= init_row + 1'b1;
      if (init_row == {BANK_ASIZE{1'b1}}) state <= ST_RUN;
    end
  end

  assign run         = !rst && (state == ST_RUN);
  assign init_active = !rst && (state == ST_INIT);
`else
  assign run         = !rst;
  assign init_active = 1'b0;
  assign init_row    = '0;
`endif

  logic [BSEL-1:0]       bank0, bank1;
  logic [BANK_ASIZE-1:0] row0, row1;
  logic                  collide, xfer0, xfer1, rd0;

  assign bank0 = req0_addr[ASIZE-1:BANK_ASIZE];
  assign row0  = req0_addr[BANK_ASIZE-1:0];
  assign bank1 = req1_addr[ASIZE-1:BANK_ASIZE];
  assign row1  = req1_addr[BANK_ASIZE-1:0];

  // Port 0 wins a same-address write/read race; port 1 just retries.
  assign collide    = req0_valid && req0_we && (req0_addr == req1_addr);
  assign req0_ready = run;
  assign req1_ready = run && !collide;
  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;
  assign rd0        = xfer0 && !req0_we;

  // During INIT every bank's port 0 is driven with the same zero write.
  logic                  b_we0;
  logic [MSIZE-1:0]      b_wmask0;
  logic [BANK_ASIZE-1:0] b_row0;
  logic [DSIZE-1:0]      b_wdata0;

  assign b_we0    = init_active || req0_we;
  assign b_wmask0 = init_active ? {MSIZE{1'b1}} : req0_wmask;
  assign b_row0   = init_active ? init_row : row0;
  assign b_wdata0 = init_active ? '0 : req0_wdata;

  logic [DSIZE-1:0] bank_rdata0 [NBANKS];
  logic [DSIZE-1:0] bank_rdata1 [NBANKS];

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    sram_bank_1rw1r #(
      .TECHNO     (TECHNO),
      .BANK_ASIZE (BANK_ASIZE),
      .DSIZE      (DSIZE),
      .MSIZE      (MSIZE)
    ) u_bank (
      .clk    (clk),
      .cs0    (init_active || (xfer0 && (bank0 == BSEL'(b)))),
      .we0    (b_we0),
      .wmask0 (b_wmask0),
      .addr0  (b_row0),
      .wdata0 (b_wdata0),
      .rdata0 (bank_rdata0[b]),
      .cs1    (xfer1 && (bank1 == BSEL'(b))),
      .addr1  (row1),
      .rdata1 (bank_rdata1[b])
    );
  end

  // Response pipeline. Bank outputs hold between reads on their port, so
  // muxing by the last-read bank gives "hold last value" for free; the
  // have_* flags give a zero rdata after reset instead of stale bank data.
  logic            rsp0_valid_q, rsp1_valid_q;
  logic            have0, have1;
  logic [BSEL-1:0] sel0, sel1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      have0        <= 1'b0;
      have1        <= 1'b0;
      sel0         <= '0;
      sel1         <= '0;
    end else begin
      rsp0_valid_q <= rd0;
      rsp1_valid_q <= xfer1;
      if (rd0) begin
        sel0  <= bank0;
        have0 <= 1'b1;
      end
      if (xfer1) begin
        sel1  <= bank1;
        have1 <= 1'b1;
      end
    end
  end

  // A response in flight when rst rises is suppressed in that same cycle.
  assign rsp0_valid = rsp0_valid_q && !rst;
  assign rsp1_valid = rsp1_valid_q && !rst;
  assign rsp0_rdata = have0 ? bank_rdata0[sel0] : '0;
  assign rsp1_rdata = have1 ? bank_rdata1[sel1] : '0;

endmodule

// File: tb/tb_generic_sram_1rw1r_banked.sv
// tb/tb_generic_sram_1rw1r_banked.sv - self-checking bench for generic_sram_1rw1r_banked

module tb_generic_sram_1rw1r_banked;
  import generic_sram_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [3:0]  req0_wmask = '0;
  logic [11:0] req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic        req1_valid = 1'b0;
  logic [11:0] req1_addr = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ref_mem [4096];
  logic [31:0] exp_last0, exp_last1;

  generic_sram_1rw1r_banked #(
    .TECHNO(TECHNO_INFERRED), .ASIZE(12), .BANK_ASIZE(10), .DSIZE(32)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_wmask(req0_wmask), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  function automatic void model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
  endfunction

  task automatic set_in(input logic v0, input logic we, input logic [3:0] m, input logic [11:0] a0,
                        input logic [31:0] d0, input logic v1, input logic [11:0] a1);
    req0_valid = v0; req0_we = we; req0_wmask = m; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_addr = a1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int cnt;
    int exp_cnt;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick;
    n_checks++; if (rsp0_valid !== 1'b0) begin n_errors++; $display("FAIL reset rsp0_valid: got %b want 0", rsp0_valid); end
    n_checks++; if (rsp1_valid !== 1'b0) begin n_errors++; $display("FAIL reset rsp1_valid: got %b want 0", rsp1_valid); end
    n_checks++; if (rsp0_rdata !== 32'h0) begin n_errors++; $display("FAIL reset rsp0_rdata: got %h want 0", rsp0_rdata); end
    n_checks++; if (rsp1_rdata !== 32'h0) begin n_errors++; $display("FAIL reset rsp1_rdata: got %h want 0", rsp1_rdata); end
    rst = 1'b0;
    exp_last0 = 32'h0;
    exp_last1 = 32'h0;
`ifdef GENERIC_SRAM_INIT_EN
    exp_cnt = 1024;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
`else
    exp_cnt = 0;
`endif
    #1;
    cnt = 0;
    while (req0_ready !== 1'b1 && cnt < 3000) begin tick; cnt++; end
    n_checks++; if (cnt != exp_cnt) begin n_errors++; $display("FAIL reset ready delay: got %0d cycles want %0d", cnt, exp_cnt); end
    n_checks++; if (req1_ready !== 1'b1) begin n_errors++; $display("FAIL reset req1_ready: got %b want 1", req1_ready); end
  endtask

  task automatic test_write_read;
    set_in(1, 1, 4'hF, 12'h005, 32'hDEADBEEF, 0, 0);
    model_write(12'h005, 32'hDEADBEEF, 4'hF);
    tick;
    set_in(0, 0, 0, 0, 0, 1, 12'h005);
    #1;
    n_checks++; if (req1_ready !== 1'b1) begin n_errors++; $display("FAIL wr_rd req1_ready: got %b want 1", req1_ready); end
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (rsp1_valid !== 1'b1) begin n_errors++; $display("FAIL wr_rd rsp1_valid: got %b want 1", rsp1_valid); end
    n_checks++; if (rsp1_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL wr_rd rsp1_rdata: got %h want deadbeef", rsp1_rdata); end
    n_checks++; if (rsp0_valid !== 1'b0) begin n_errors++; $display("FAIL wr_rd rsp0_valid: got %b want 0", rsp0_valid); end
    exp_last1 = 32'hDEADBEEF;
    tick;
    n_checks++; if (rsp1_valid !== 1'b0) begin n_errors++; $display("FAIL wr_rd pulse: got %b want 0", rsp1_valid); end
    n_checks++; if (rsp1_rdata !== exp_last1) begin n_errors++; $display("FAIL wr_rd hold: got %h want %h", rsp1_rdata, exp_last1); end
  endtask

  task automatic test_byte_mask;
    logic [31:0] exp;
    set_in(1, 1, 4'b0101, 12'h005, 32'h11223344, 0, 0);
    model_write(12'h005, 32'h11223344, 4'b0101);
    tick;
    set_in(1, 0, 0, 12'h005, 0, 0, 0);
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0);
    exp = ref_mem[12'h005];
    n_checks++; if (rsp0_valid !== 1'b1) begin n_errors++; $display("FAIL mask rsp0_valid: got %b want 1", rsp0_valid); end
    n_checks++; if (rsp0_rdata !== 32'hDE22BE44 || exp !== 32'hDE22BE44) begin n_errors++; $display("FAIL mask rdata: got %h want de22be44", rsp0_rdata); end
    exp_last0 = exp;
    // zero mask: accepted, no change
    set_in(1, 1, 4'b0000, 12'h005, 32'hFFFFFFFF, 0, 0);
    #1;
    n_checks++; if (req0_ready !== 1'b1) begin n_errors++; $display("FAIL mask0 req0_ready: got %b want 1", req0_ready); end
    tick;
    n_checks++; if (rsp0_valid !== 1'b0) begin n_errors++; $display("FAIL mask0 write response: got %b want 0", rsp0_valid); end
    set_in(1, 0, 0, 12'h005, 0, 0, 0);
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (rsp0_rdata !== 32'hDE22BE44) begin n_errors++; $display("FAIL mask0 rdata: got %h want de22be44", rsp0_rdata); end
  endtask

  task automatic test_bank_isolation;
    set_in(1, 1, 4'hF, 12'h3FF, 32'hA5A5A5A5, 0, 0);
    model_write(12'h3FF, 32'hA5A5A5A5, 4'hF);
    tick;
    set_in(1, 1, 4'hF, 12'h400, 32'h5A5A5A5A, 0, 0);
    model_write(12'h400, 32'h5A5A5A5A, 4'hF);
    tick;
    set_in(0, 0, 0, 0, 0, 1, 12'h3FF);
    tick;
    set_in(0, 0, 0, 0, 0, 1, 12'h400);
    n_checks++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'hA5A5A5A5) begin n_errors++; $display("FAIL bank 0x3ff: got v=%b %h want v=1 a5a5a5a5", rsp1_valid, rsp1_rdata); end
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h5A5A5A5A) begin n_errors++; $display("FAIL bank 0x400: got v=%b %h want v=1 5a5a5a5a", rsp1_valid, rsp1_rdata); end
    exp_last1 = 32'h5A5A5A5A;
    // both ports read the same address in one cycle
    set_in(1, 0, 0, 12'h3FF, 0, 1, 12'h3FF);
    #1;
    n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin n_errors++; $display("FAIL dual ready: got %b%b want 11", req0_ready, req1_ready); end
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (rsp0_rdata !== 32'hA5A5A5A5 || rsp1_rdata !== 32'hA5A5A5A5 || !rsp0_valid || !rsp1_valid)
      begin n_errors++; $display("FAIL dual read: got %h/%h want a5a5a5a5 both", rsp0_rdata, rsp1_rdata); end
    exp_last0 = 32'hA5A5A5A5;
    exp_last1 = 32'hA5A5A5A5;
  endtask

  task automatic test_collision;
    set_in(1, 1, 4'hF, 12'h124, 32'h12345678, 0, 0);
    model_write(12'h124, 32'h12345678, 4'hF);
    tick;
    set_in(1, 1, 4'hF, 12'h123, 32'hCAFEF00D, 1, 12'h123);
    #1;
    n_checks++; if (req1_ready !== 1'b0) begin n_errors++; $display("FAIL collide req1_ready: got %b want 0", req1_ready); end
    n_checks++; if (req0_ready !== 1'b1) begin n_errors++; $display("FAIL collide req0_ready: got %b want 1", req0_ready); end
    model_write(12'h123, 32'hCAFEF00D, 4'hF);
    tick;
    set_in(0, 0, 0, 0, 0, 1, 12'h123);
    #1;
    n_checks++; if (rsp1_valid !== 1'b0) begin n_errors++; $display("FAIL collide stalled rsp: got %b want 0", rsp1_valid); end
    n_checks++; if (req1_ready !== 1'b1) begin n_errors++; $display("FAIL collide retry ready: got %b want 1", req1_ready); end
    tick;
    n_checks++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'hCAFEF00D) begin n_errors++; $display("FAIL collide retry data: got v=%b %h want v=1 cafef00d", rsp1_valid, rsp1_rdata); end
    set_in(1, 1, 4'hF, 12'h123, 32'hCAFEF00D, 1, 12'h124);
    #1;
    n_checks++; if (req1_ready !== 1'b1) begin n_errors++; $display("FAIL nocollide ready: got %b want 1", req1_ready); end
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h12345678) begin n_errors++; $display("FAIL nocollide data: got v=%b %h want v=1 12345678", rsp1_valid, rsp1_rdata); end
    exp_last1 = 32'h12345678;
  endtask

  task automatic test_fill;
    logic [31:0] d;
    for (int a = 0; a < 4096; a++) begin
      d = $urandom;
      set_in(1, 1, 4'hF, 12'(a), d, 0, 0);
      model_write(12'(a), d, 4'hF);
      tick;
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random;
    logic        v0, we, v1, exp_r1, rd0, rd1;
    logic [3:0]  m;
    logic [11:0] a0, a1;
    logic [31:0] d, e0, e1;
    for (int n = 0; n < 2000; n++) begin
      v0 = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1);
      m  = 4'($urandom);
      d  = $urandom;
      v1 = ($urandom_range(0, 3) != 0);
      a1 = 12'($urandom);
      a0 = ($urandom_range(0, 3) == 0) ? a1 : 12'($urandom);
      set_in(v0, we, m, a0, d, v1, a1);
      #1;
      exp_r1 = !(v0 && we && (a0 == a1));
      n_checks++; if (req0_ready !== 1'b1) begin n_errors++; $display("FAIL rand req0_ready @%0d: got %b want 1", n, req0_ready); end
      n_checks++; if (req1_ready !== exp_r1) begin n_errors++; $display("FAIL rand req1_ready @%0d: got %b want %b", n, req1_ready, exp_r1); end
      rd0 = v0 && !we;
      rd1 = v1 && exp_r1;
      e0 = ref_mem[a0];
      e1 = ref_mem[a1];
      if (v0 && we) model_write(a0, d, m);
      tick;
      n_checks++; if (rsp0_valid !== rd0) begin n_errors++; $display("FAIL rand rsp0_valid @%0d: got %b want %b", n, rsp0_valid, rd0); end
      n_checks++; if (rsp1_valid !== rd1) begin n_errors++; $display("FAIL rand rsp1_valid @%0d: got %b want %b", n, rsp1_valid, rd1); end
      if (rd0) exp_last0 = e0;
      if (rd1) exp_last1 = e1;
      n_checks++; if (rsp0_rdata !== exp_last0) begin n_errors++; $display("FAIL rand rsp0_rdata @%0d: got %h want %h", n, rsp0_rdata, exp_last0); end
      n_checks++; if (rsp1_rdata !== exp_last1) begin n_errors++; $display("FAIL rand rsp1_rdata @%0d: got %h want %h", n, rsp1_rdata, exp_last1); end
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_read;
    int cnt;
    logic [31:0] exp;
    set_in(1, 0, 0, 12'h777, 0, 1, 12'h778);
    tick;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_errors++; $display("FAIL midrst valid: got %b%b want 00", rsp0_valid, rsp1_valid); end
    tick;
    n_checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_errors++; $display("FAIL midrst valid2: got %b%b want 00", rsp0_valid, rsp1_valid); end
    tick;
    n_checks++; if (rsp0_rdata !== 32'h0 || rsp1_rdata !== 32'h0) begin n_errors++; $display("FAIL midrst rdata: got %h/%h want 0", rsp0_rdata, rsp1_rdata); end
    rst = 1'b0;
`ifdef GENERIC_SRAM_INIT_EN
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
`endif
    #1;
    cnt = 0;
    while (req0_ready !== 1'b1 && cnt < 3000) begin tick; cnt++; end
    n_checks++; if (req0_ready !== 1'b1) begin n_errors++; $display("FAIL midrst ready timeout: got %b want 1", req0_ready); end
    n_checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_errors++; $display("FAIL midrst idle valid: got %b%b want 00", rsp0_valid, rsp1_valid); end
    set_in(1, 0, 0, 12'h777, 0, 1, 12'h777);
    exp = ref_mem[12'h777];
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== exp) begin n_errors++; $display("FAIL midrst keep p0: got v=%b %h want v=1 %h", rsp0_valid, rsp0_rdata, exp); end
    n_checks++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== exp) begin n_errors++; $display("FAIL midrst keep p1: got v=%b %h want v=1 %h", rsp1_valid, rsp1_rdata, exp); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_byte_mask;
    test_bank_isolation;
    test_collision;
    test_fill;
    test_random;
    test_reset_mid_read;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
